sha256_msg_feeder: RTL

Byte-stream front end for the `sha256` compression core. It accepts a message one byte at a time and applies SHA-256 padding and the 64-bit length field. It packs the bytes into 512-bit blocks and drives the core's `M_in`/`H_in`/`input_valid` side. It chains each returned `H_out` into the next block and presents the final 256-bit digest. In the Hash160 datapath it sits between the message source and `sha256`; its digest feeds the RIPEMD-160 stage.

---
 rtl/sha256_pkg.sv | 31 +++
 rtl/sha256_block_packer.sv | 54 +++++
 rtl/sha256_msg_feeder.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 byte-stream feeder.
// Holds the initial hash value, FSM states and block geometry.
package sha256_pkg;

  localparam int BLK_W     = 512;
  localparam int BLK_BYTES = 64;
  localparam int LEN_OFF   = 56;

  localparam logic [255:0] H_0 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_PAD,
    S_LEN,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP,
    OP_WR,
    OP_PAD,
    OP_LEN
  } pk_op_t;

endpackage

// File: rtl/sha256_block_packer.sv
// 64-byte block register with byte-write, pad and length-insert ops.
// Byte 0 of the block sits at the top of o_block.
module sha256_block_packer
  import sha256_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  pk_op_t           i_op,
  input  logic [5:0]       i_idx,
  input  logic [7:0]       i_data,
  input  logic             i_len_en,
  input  logic [63:0]      i_bitlen,
  output logic [BLK_W-1:0] o_block
);

  logic [7:0]       r_mem [BLK_BYTES];
  logic [BLK_W-1:0] w_lenblk;

  // Length field laid out as a full block so every byte index is in range
  assign w_lenblk = {{(BLK_W-64){1'b0}}, i_bitlen};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BLK_BYTES; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < BLK_BYTES; i++) begin
        unique case (i_op)
          OP_WR: begin
            if (i == int'(i_idx)) r_mem[i] <= i_data;
          end
          OP_PAD: begin
            if (i == int'(i_idx)) begin
              r_mem[i] <= 8'h80;
            end else if (i > int'(i_idx)) begin
              r_mem[i] <= i_len_en ?
                w_lenblk[BLK_W-1-8*i -: 8] : 8'h00;
            end
          end
          OP_LEN: begin
            r_mem[i] <= w_lenblk[BLK_W-1-8*i -: 8];
          end
          default: ;
        endcase
      end
    end
  end

  for (genvar g = 0; g < BLK_BYTES; g++) begin : g_out
    assign o_block[BLK_W-1-8*g -: 8] = r_mem[g];
  end

endmodule

// File: rtl/sha256_msg_feeder.sv
// SHA-256 message feeder: packs bytes, pads, chains H, emits digest.
// Optional watchdog on the core handshake: SHA256_FEEDER_WATCHDOG_EN.
module sha256_msg_feeder
  import sha256_pkg::*;
#(
  parameter int LEN_W     = 32,
  parameter int WD_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [BLK_W-1:0] M_out,
  output logic [255:0]     H_chain,
  output logic             core_valid,
  input  logic [255:0]     core_H,
  input  logic             core_done,
  output logic [255:0]     digest,
  output logic             digest_valid,
  output logic             busy
`ifdef SHA256_FEEDER_WATCHDOG_EN
  ,
  output logic             wd_err
`endif
);

  state_t           r_state;
  state_t           w_next;
  logic [6:0]       r_idx;
  logic [LEN_W-1:0] r_byte_cnt;
  logic             r_final;
  logic             r_pad_pend;
  logic             r_len_pend;
  logic [255:0]     r_H_chain;
  logic [255:0]     r_digest;
  logic             w_xfer;
  logic             w_len_en;
  logic [63:0]      w_bitlen;
  pk_op_t           w_op;

  assign in_ready = !rst && (r_idx < 7'd64) &&
                    (r_state == S_IDLE || r_state == S_FILL);
  assign w_xfer   = in_valid && in_ready;
  assign w_bitlen = 64'(r_byte_cnt) << 3;
  assign w_len_en = (r_idx <= 7'(LEN_OFF - 1));
  assign H_chain  = r_H_chain;
  assign digest   = r_digest;

`ifdef SHA256_FEEDER_WATCHDOG_EN
  localparam int WD_W = (WD_CYCLES > 1) ? $clog2(WD_CYCLES + 1) : 1;
  logic [WD_W-1:0] r_wd_cnt;
  logic            w_wd_hit;
  assign w_wd_hit = (r_wd_cnt == WD_W'(WD_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_wd_cnt <= '0;
    else if (r_state == S_WAIT) r_wd_cnt <= r_wd_cnt + 1'b1;
    else r_wd_cnt <= '0;
  end
`else
  logic w_unused_wd;
  assign w_unused_wd = |32'(WD_CYCLES);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_op         = OP_NOP;
    core_valid   = 1'b0;
    digest_valid = 1'b0;
    busy         = (r_state != S_IDLE);
`ifdef SHA256_FEEDER_WATCHDOG_EN
    wd_err       = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_op   = OP_WR;
          w_next = in_last ? S_PAD : S_FILL;
        end
      end
      S_FILL: begin
        if (w_xfer) begin
          w_op = OP_WR;
          if (r_idx == 7'd63) w_next = S_ISSUE;
          else if (in_last) w_next = S_PAD;
        end
      end
      S_PAD: begin
        w_op   = OP_PAD;
        w_next = S_ISSUE;
      end
      S_LEN: begin
        w_op   = OP_LEN;
        w_next = S_ISSUE;
      end
      S_ISSUE: begin
        core_valid = 1'b1;
        w_next     = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          if (r_final) w_next = S_DONE;
          else if (r_pad_pend) w_next = S_PAD;
          else if (r_len_pend) w_next = S_LEN;
          else w_next = S_FILL;
        end
`ifdef SHA256_FEEDER_WATCHDOG_EN
        else if (w_wd_hit) begin
          wd_err = 1'b1;
          w_next = S_IDLE;
        end
`endif
      end
      S_DONE: begin
        digest_valid = 1'b1;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx      <= '0;
      r_byte_cnt <= '0;
      r_final    <= 1'b0;
      r_pad_pend <= 1'b0;
      r_len_pend <= 1'b0;
      r_H_chain  <= '0;
      r_digest   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_H_chain  <= H_0;
          r_final    <= 1'b0;
          r_pad_pend <= 1'b0;
          r_len_pend <= 1'b0;
          r_idx      <= w_xfer ? 7'd1 : 7'd0;
          r_byte_cnt <= w_xfer ? LEN_W'(1) : '0;
        end
        S_FILL: begin
          if (w_xfer) begin
            r_idx      <= r_idx + 7'd1;
            r_byte_cnt <= r_byte_cnt + 1'b1;
            // Last byte filled the block: padding goes in a fresh block
            if (in_last && r_idx == 7'd63) r_pad_pend <= 1'b1;
          end
        end
        S_PAD: begin
          r_final    <= w_len_en;
          r_len_pend <= !w_len_en;
        end
        S_LEN: r_final <= 1'b1;
        S_WAIT: begin
          if (core_done) begin
            r_H_chain  <= core_H;
            r_idx      <= '0;
            r_pad_pend <= 1'b0;
            r_len_pend <= 1'b0;
            if (r_final) r_digest <= core_H;
          end
        end
        S_DONE: r_idx <= '0;
        default: ;
      endcase
    end
  end

  sha256_block_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .i_op     (w_op),
    .i_idx    (r_idx[5:0]),
    .i_data   (in_data),
    .i_len_en (w_len_en),
    .i_bitlen (w_bitlen),
    .o_block  (M_out)
  );

endmodule
